elevator_scheduler: RTL and testbench
=====================================

// Module: elevator_scheduler
// PURPOSE
// Car controller for the elevator: reads the latched call registers from the button block (cabin, hall-up, hall-down),
// runs a SCAN (collective-selective) policy, steps the car floor by floor, times the door, and returns one-cycle
// inactivate pulses that clear served calls in the button block. Sits between the button register block and motor/door drivers.
// PARAMETERS
// FLOORS         8   number of floors, >=2
// FLOOR_W        3   floor index width, 2**FLOOR_W >= FLOORS
// TRAVEL_CYCLES  4   clocks to move one floor, >=1
// DOOR_CYCLES    6   clocks door stays open per (re)open, >=1
// PORTS
// clk                         in   1         system clock, rising edge
// reset                       in   1         asynchronous, active-high
// active_in_levels            in   FLOORS    cabin call pending per floor
// active_out_up_levels        in   FLOORS-1  hall-up call, floors 0..FLOORS-2
// active_out_down_levels      in   FLOORS-1  hall-down call, floors 1..FLOORS-1 ([FLOORS-1:1])
// inactivate_in_levels        out  FLOORS    1-cycle clear pulse, cabin call
// inactivate_out_up_levels    out  FLOORS-1  1-cycle clear pulse, hall-up ([FLOORS-2:0])
// inactivate_out_down_levels  out  FLOORS-1  1-cycle clear pulse, hall-down ([FLOORS-1:1])
// current_floor               out  FLOOR_W   floor the car is at / last passed
// dir_up                      out  1         1 = travelling/serving up, 0 = down
// motor_up, motor_down        out  1         drive commands, never both 1
// door_open                   out  1         door command
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, current_floor=0, dir_up=1, timer=0; motor_*, door_open, all inactivate_* = 0.
// - req_above/req_below = OR of all three call vectors at floors >/< current_floor. All outputs registered.
// - serve(f) = in[f] | (dir_up ? up[f] : down[f]) | (no calls beyond f in dir_up & opposite-hall[f]); in the last case dir_up flips.
// - IDLE: call at current_floor -> DOOR (dir flip per serve rule). Else req in dir_up direction -> MOVING;
//   else req opposite -> flip dir_up, MOVING; else stay. One clock from decision to motor/door asserting.
// - MOVING: motor_up=dir_up, motor_down=~dir_up; timer counts 0..TRAVEL_CYCLES-1; at terminal count
//   current_floor +/-1, timer=0; if serve(new floor) -> DOOR, else continue (motor stays on, no gap).
// - DOOR: door_open=1, motors 0, timer counts DOOR_CYCLES. On entry cycle pulse inactivate for in[cur] and the
//   hall call(s) served. A new in[cur] or same-direction hall call at cur while open -> pulse its inactivate,
//   timer restarts. At terminal count -> IDLE (door_open drops that edge).
// - Bounds: at floor FLOORS-1 dir_up forced 0, at floor 0 forced 1; never steps past either end; non-existent
//   hall bits (down[0], up[FLOORS-1]) never referenced. current_floor never wraps.
// - Inactivate pulses exactly 1 cycle, only for bits set that cycle; a call asserted in the same cycle the car
//   leaves a floor is not cleared and is served on a later visit.
// - Reset mid-motion or mid-door: immediate return to reset values; car position re-taken as floor 0.
// TESTING (FLOORS=8, TRAVEL_CYCLES=4, DOOR_CYCLES=6)
// 1 reset, hold in[3] -> motor_up 12 cycles, floor 0->1->2->3, door_open 6 cycles, inactivate_in[3] 1 pulse, IDLE.
// 2 in[5] from 0; up[2] set at floor 1 -> stop at 2, clear up[2] only; down[2] set instead -> no stop at 2.
// 3 only down[4] from 0 -> travel to 4, dir_up flips to 0 at arrival, inactivate_down[4] pulse, no up pulse.
// 4 IDLE at 0, in[0] -> door_open next cycle, motors never assert, inactivate_in[0] pulse; repress in[0] during door -> timer restarts.
// 5 in[7] and in[0] from floor 2 (dir up) -> go to 7, dir_up=0 there, then motor_down 28 cycles to 0.
// 6 reset pulse while MOVING at floor 2 -> same cycle all outputs 0, current_floor=0, dir_up=1; no inactivate pulse.

Source files
------------

// File: rtl/elevator_scheduler.sv
// Elevator car controller: SCAN (collective-selective) scheduling over the latched
// call registers, floor-by-floor travel timing, door timing, and one-cycle clear
// pulses back to the button register block.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | car parked, door closed; picks door / direction from the calls
// MOVING | motor on in dir_up direction; timer paces one floor per period
// DOOR   | door open at current_floor; timer restarts on a fresh call here
module elevator_scheduler #(
    parameter int FLOORS        = 8,
    parameter int FLOOR_W       = 3,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FLOORS-1:0]  active_in_levels,
    input  logic [FLOORS-2:0]  active_out_up_levels,
    input  logic [FLOORS-1:1]  active_out_down_levels,
    output logic [FLOORS-1:0]  inactivate_in_levels,
    output logic [FLOORS-2:0]  inactivate_out_up_levels,
    output logic [FLOORS-1:1]  inactivate_out_down_levels,
    output logic [FLOOR_W-1:0] current_floor,
    output logic               dir_up,
    output logic               motor_up,
    output logic               motor_down,
    output logic               door_open
);

    localparam int T_MAX   = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TIMER_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);
    localparam logic [TIMER_W-1:0] TRAVEL_TC = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_TC   = TIMER_W'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVING = 2'd1,
        DOOR   = 2'd2
    } state_t;

    state_t              state;
    logic [TIMER_W-1:0]  timer;

    // Hall vectors padded to full width; the missing end bits are constant zero.
    logic [FLOORS-1:0]   up_full;
    logic [FLOORS-1:0]   down_full;
    logic [FLOORS-1:0]   calls;
    logic [FLOORS-1:0]   prev_in;
    logic [FLOORS-1:0]   prev_up;
    logic [FLOORS-1:0]   prev_dn;
    logic [FLOORS-1:0]   onehot;

    logic [FLOOR_W-1:0]  ef;
    logic                eff_dir;
    logic                above;
    logic                below;
    logic                fwd;
    logic                rev;
    logic                cont;
    logic                same_hall;
    logic                opp_hall;
    logic                flip;
    logic                serve;
    logic                new_dir;
    logic                travel_tc;
    logic                p_in;
    logic                p_up;
    logic                p_dn;

    assign up_full   = {1'b0, active_out_up_levels};
    assign down_full = {active_out_down_levels, 1'b0};
    assign calls     = active_in_levels | up_full | down_full;
    assign prev_in   = inactivate_in_levels;
    assign prev_up   = {1'b0, inactivate_out_up_levels};
    assign prev_dn   = {inactivate_out_down_levels, 1'b0};
    assign travel_tc = (timer == TRAVEL_TC);
    assign onehot    = {{(FLOORS-1){1'b0}}, 1'b1} << ef;

    // Evaluate the serve rule at the floor of interest: the current floor, or the
    // floor being arrived at while moving. End floors force the direction.
    always_comb begin
        ef = current_floor;
        if (state == MOVING) begin
            if (dir_up && current_floor != TOP_FLOOR)
                ef = current_floor + FLOOR_W'(1);
            else if (!dir_up && current_floor != '0)
                ef = current_floor - FLOOR_W'(1);
        end
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (calls[i] && (i > int'(ef))) above = 1'b1;
            if (calls[i] && (i < int'(ef))) below = 1'b1;
        end
        if (ef == TOP_FLOOR)
            eff_dir = 1'b0;
        else if (ef == '0)
            eff_dir = 1'b1;
        else
            eff_dir = dir_up;
        fwd       = eff_dir ? above : below;
        rev       = eff_dir ? below : above;
        cont      = dir_up ? above : below;
        same_hall = eff_dir ? up_full[ef] : down_full[ef];
        opp_hall  = eff_dir ? down_full[ef] : up_full[ef];
        flip      = ~fwd & opp_hall & ~same_hall;
        serve     = active_in_levels[ef] | same_hall | flip;
        new_dir   = flip ? ~eff_dir : eff_dir;
    end

    // Decide which calls at the evaluated floor get a clear pulse this cycle.
    // While the door is open, a bit still showing last cycle's pulse is stale.
    always_comb begin
        p_in = 1'b0;
        p_up = 1'b0;
        p_dn = 1'b0;
        case (state)
            IDLE, MOVING: begin
                if (serve && (state == IDLE || travel_tc)) begin
                    p_in = active_in_levels[ef];
                    p_up = new_dir & up_full[ef];
                    p_dn = ~new_dir & down_full[ef];
                end
            end
            DOOR: begin
                p_in = active_in_levels[ef] & ~prev_in[ef];
                p_up = dir_up & up_full[ef] & ~prev_up[ef];
                p_dn = ~dir_up & down_full[ef] & ~prev_dn[ef];
            end
            default: ;
        endcase
    end

    // Car FSM with registered motor, door, direction, floor and pulse outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                      <= IDLE;
            timer                      <= '0;
            current_floor              <= '0;
            dir_up                     <= 1'b1;
            motor_up                   <= 1'b0;
            motor_down                 <= 1'b0;
            door_open                  <= 1'b0;
            inactivate_in_levels       <= '0;
            inactivate_out_up_levels   <= '0;
            inactivate_out_down_levels <= '0;
        end else begin
            inactivate_in_levels       <= onehot & {FLOORS{p_in}};
            inactivate_out_up_levels   <= onehot[FLOORS-2:0] & {(FLOORS-1){p_up}};
            inactivate_out_down_levels <= onehot[FLOORS-1:1] & {(FLOORS-1){p_dn}};
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (serve) begin
                        state     <= DOOR;
                        door_open <= 1'b1;
                        dir_up    <= new_dir;
                    end else if (fwd) begin
                        state      <= MOVING;
                        dir_up     <= eff_dir;
                        motor_up   <= eff_dir;
                        motor_down <= ~eff_dir;
                    end else if (rev) begin
                        state      <= MOVING;
                        dir_up     <= ~eff_dir;
                        motor_up   <= ~eff_dir;
                        motor_down <= eff_dir;
                    end else begin
                        dir_up <= eff_dir;
                    end
                end
                MOVING: begin
                    if (travel_tc) begin
                        timer         <= '0;
                        current_floor <= ef;
                        if (serve) begin
                            state      <= DOOR;
                            motor_up   <= 1'b0;
                            motor_down <= 1'b0;
                            door_open  <= 1'b1;
                            dir_up     <= new_dir;
                        end else if (!cont) begin
                            // Calls ahead were withdrawn; park and re-decide.
                            state      <= IDLE;
                            motor_up   <= 1'b0;
                            motor_down <= 1'b0;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DOOR: begin
                    if (p_in || p_up || p_dn) begin
                        timer <= '0;
                    end else if (timer == DOOR_TC) begin
                        state     <= IDLE;
                        door_open <= 1'b0;
                        timer     <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    motor_up   <= 1'b0;
                    motor_down <= 1'b0;
                    door_open  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: a latched button-block model feeds the car, a
// monitor logs door openings and clear pulses, and the directed sequence pushes the
// expected event order to a scoreboard queue that is compared after each scenario.
module tb_elevator_scheduler;

    localparam int EV_DOOR = 0;
    localparam int EV_IN   = 16;
    localparam int EV_UP   = 32;
    localparam int EV_DN   = 48;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;

    logic [7:0] btn_in   = '0;
    logic [6:0] btn_up   = '0;
    logic [7:1] btn_dn   = '0;
    logic [7:0] press_in = '0;
    logic [6:0] press_up = '0;
    logic [7:1] press_dn = '0;

    logic [7:0] inactivate_in_levels;
    logic [6:0] inactivate_out_up_levels;
    logic [7:1] inactivate_out_down_levels;
    logic [2:0] current_floor;
    logic       dir_up;
    logic       motor_up;
    logic       motor_down;
    logic       door_open;

    int total = 0;
    int bad   = 0;
    int obs_q[$];
    int exp_q[$];
    int obs_rd = 0;
    int mu_cnt = 0;
    int md_cnt = 0;
    int door_cnt = 0;
    int both_cnt = 0;
    logic door_q = 1'b0;

    elevator_scheduler #(
        .FLOORS(8), .FLOOR_W(3), .TRAVEL_CYCLES(4), .DOOR_CYCLES(6)
    ) dut (
        .clk                        (clk),
        .reset                      (reset),
        .active_in_levels           (btn_in),
        .active_out_up_levels       (btn_up),
        .active_out_down_levels     (btn_dn),
        .inactivate_in_levels       (inactivate_in_levels),
        .inactivate_out_up_levels   (inactivate_out_up_levels),
        .inactivate_out_down_levels (inactivate_out_down_levels),
        .current_floor              (current_floor),
        .dir_up                     (dir_up),
        .motor_up                   (motor_up),
        .motor_down                 (motor_down),
        .door_open                  (door_open)
    );

    always #5 clk = ~clk;

    // Button block model plus event monitor, both on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            btn_in = '0;
            btn_up = '0;
            btn_dn = '0;
            door_q = 1'b0;
        end else begin
            if (door_open && !door_q) obs_q.push_back(EV_DOOR + int'(current_floor));
            door_q = door_open;
            for (int i = 0; i < 8; i++)
                if (inactivate_in_levels[i]) obs_q.push_back(EV_IN + i);
            for (int i = 0; i < 7; i++)
                if (inactivate_out_up_levels[i]) obs_q.push_back(EV_UP + i);
            for (int i = 1; i < 8; i++)
                if (inactivate_out_down_levels[i]) obs_q.push_back(EV_DN + i);
            if (motor_up) mu_cnt++;
            if (motor_down) md_cnt++;
            if (door_open) door_cnt++;
            if (motor_up && motor_down) both_cnt++;
            btn_in = (btn_in & ~inactivate_in_levels) | press_in;
            btn_up = (btn_up & ~inactivate_out_up_levels) | press_up;
            btn_dn = (btn_dn & ~inactivate_out_down_levels) | press_dn;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic press(input logic [7:0] pin, input logic [6:0] pup, input logic [7:1] pdn);
        @(posedge clk);
        #1;
        press_in = pin;
        press_up = pup;
        press_dn = pdn;
        @(posedge clk);
        #1;
        press_in = '0;
        press_up = '0;
        press_dn = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic settle(input string tag);
        int n;
        int quiet;
        n = 0;
        quiet = 0;
        while (quiet < 3 && n < 400) begin
            @(negedge clk);
            n++;
            if (!door_open && !motor_up && !motor_down &&
                btn_in == '0 && btn_up == '0 && btn_dn == '0)
                quiet++;
            else
                quiet = 0;
        end
        chk({tag, "_settle"}, 32'(quiet >= 3), 1);
    endtask

    task automatic wait_floor(input logic [2:0] f, input string tag);
        int n;
        n = 0;
        while (current_floor != f && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_reach_floor"}, 32'(current_floor), 32'(f));
    endtask

    task automatic wait_door(input string tag);
        int n;
        n = 0;
        while (!door_open && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_door_opened"}, 32'(door_open), 1);
    endtask

    task automatic check_events(input string tag);
        int k;
        int e;
        int o;
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = -1;
            if (obs_rd < obs_q.size()) begin
                o = obs_q[obs_rd];
                obs_rd++;
            end
            chk($sformatf("%s_ev%0d", tag, k), o, e);
            k++;
        end
        chk({tag, "_extra_events"}, obs_q.size() - obs_rd, 0);
    endtask

    initial begin
        int mu0;
        int md0;
        int dr0;
        int n;

        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_floor", 32'(current_floor), 0);
        chk("rst_dir", 32'(dir_up), 1);
        chk("rst_motors", 32'({motor_up, motor_down}), 0);
        chk("rst_door", 32'(door_open), 0);
        chk("rst_pulses", 32'({inactivate_in_levels, inactivate_out_up_levels,
                               inactivate_out_down_levels}), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_motors", 32'({motor_up, motor_down, door_open}), 0);

        // Cabin call at the parked floor, then a re-press while the door is open.
        mu0 = mu_cnt;
        md0 = md_cnt;
        press(8'h01, '0, '0);
        @(negedge clk);
        chk("t4_door_latency", 32'(door_open), 1);
        chk("t4_pulse_in0", 32'(inactivate_in_levels), 32'h01);
        exp_q.push_back(EV_DOOR + 0);
        exp_q.push_back(EV_IN + 0);
        exp_q.push_back(EV_IN + 0);
        press(8'h01, '0, '0);
        @(negedge clk);
        chk("t4_repulse_in0", 32'(inactivate_in_levels), 32'h01);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!door_open) break;
            n++;
        end
        chk("t4_door_after_restart", n, 6);
        settle("t4");
        chk("t4_no_motion", (mu_cnt - mu0) + (md_cnt - md0), 0);
        check_events("t4");

        // Single cabin call three floors up.
        do_reset();
        mu0 = mu_cnt;
        md0 = md_cnt;
        dr0 = door_cnt;
        press(8'h08, '0, '0);
        @(negedge clk);
        chk("t1_motor_latency", 32'(motor_up), 1);
        exp_q.push_back(EV_DOOR + 3);
        exp_q.push_back(EV_IN + 3);
        settle("t1");
        chk("t1_motor_up_cycles", mu_cnt - mu0, 12);
        chk("t1_motor_down_cycles", md_cnt - md0, 0);
        chk("t1_door_cycles", door_cnt - dr0, 6);
        chk("t1_floor", 32'(current_floor), 3);
        check_events("t1");

        // Hall-up call picked up on the way.
        do_reset();
        press(8'h20, '0, '0);
        wait_floor(3'd1, "t2a");
        press('0, 7'h04, '0);
        exp_q.push_back(EV_DOOR + 2);
        exp_q.push_back(EV_UP + 2);
        exp_q.push_back(EV_DOOR + 5);
        exp_q.push_back(EV_IN + 5);
        settle("t2a");
        chk("t2a_floor", 32'(current_floor), 5);
        check_events("t2a");

        // Hall-down call passed going up, served on the way back down.
        do_reset();
        press(8'h20, '0, '0);
        wait_floor(3'd1, "t2b");
        press('0, '0, 7'b0000010);
        exp_q.push_back(EV_DOOR + 5);
        exp_q.push_back(EV_IN + 5);
        exp_q.push_back(EV_DOOR + 2);
        exp_q.push_back(EV_DN + 2);
        settle("t2b");
        chk("t2b_floor", 32'(current_floor), 2);
        chk("t2b_dir", 32'(dir_up), 0);
        check_events("t2b");

        // Only a hall-down call above: direction flips on arrival.
        do_reset();
        press('0, '0, 7'b0001000);
        wait_door("t3");
        chk("t3_floor", 32'(current_floor), 4);
        chk("t3_dir_at_arrival", 32'(dir_up), 0);
        exp_q.push_back(EV_DOOR + 4);
        exp_q.push_back(EV_DN + 4);
        settle("t3");
        chk("t3_dir_idle", 32'(dir_up), 0);
        check_events("t3");

        // From floor 2 going up: top floor first, then all the way down.
        do_reset();
        press(8'h04, '0, '0);
        exp_q.push_back(EV_DOOR + 2);
        exp_q.push_back(EV_IN + 2);
        settle("t5pre");
        chk("t5_start_floor", 32'(current_floor), 2);
        chk("t5_start_dir", 32'(dir_up), 1);
        mu0 = mu_cnt;
        press(8'h81, '0, '0);
        wait_door("t5top");
        chk("t5_top_floor", 32'(current_floor), 7);
        chk("t5_top_dir", 32'(dir_up), 0);
        chk("t5_up_cycles", mu_cnt - mu0, 20);
        md0 = md_cnt;
        exp_q.push_back(EV_DOOR + 7);
        exp_q.push_back(EV_IN + 7);
        exp_q.push_back(EV_DOOR + 0);
        exp_q.push_back(EV_IN + 0);
        settle("t5");
        chk("t5_down_cycles", md_cnt - md0, 28);
        chk("t5_end_floor", 32'(current_floor), 0);
        check_events("t5");

        // Asynchronous reset while travelling.
        do_reset();
        press(8'h20, '0, '0);
        wait_floor(3'd2, "t6");
        chk("t6_moving", 32'(motor_up), 1);
        #2 reset = 1'b1;
        #1;
        chk("t6_floor", 32'(current_floor), 0);
        chk("t6_dir", 32'(dir_up), 1);
        chk("t6_outputs", 32'({motor_up, motor_down, door_open}), 0);
        chk("t6_pulses", 32'({inactivate_in_levels, inactivate_out_up_levels,
                              inactivate_out_down_levels}), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        settle("t6");
        chk("t6_floor_after", 32'(current_floor), 0);
        check_events("t6");

        chk("motors_never_both", both_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
